// File: rtl/core0_progloader.sv
// Program loader for core0: streams bytes into program memory while holding the
// core in reset, primes the synchronous read port, then hands memory to the core.
module core0_progloader #(
    parameter int PROGRAM_ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_start,
    input  logic [PROGRAM_ADDR_WIDTH:0]   load_len,
    input  logic                          run_start,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] core_pm_addr,
    input  logic [7:0]                    core_pm_write_value,
    input  logic                          core_pm_we,
    output logic [PROGRAM_ADDR_WIDTH-1:0] pm_addr,
    output logic [7:0]                    pm_write_value,
    output logic                          pm_we,
    output logic                          core_reset,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int AW = PROGRAM_ADDR_WIDTH;
    localparam logic [AW:0] PROGRAM_SIZE = (AW+1)'(2**AW);

    typedef enum logic [1:0] {
        HALT,
        LOAD,
        PRIME,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   len_q,   len_d;
    logic          error_q, error_d;
    logic          len_ok;
    logic [AW:0]   count_inc;

    assign len_ok    = (load_len != '0) && (load_len <= PROGRAM_SIZE);
    assign count_inc = count_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HALT;
            count_q <= '0;
            len_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            error_q <= error_d;
        end
    end

    // Next-state logic; load_start wins over run_start, and a rejected load leaves state alone
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        error_d = 1'b0;
        unique case (state_q)
            HALT, RUN: begin
                if (load_start) begin
                    if (len_ok) begin
                        state_d = LOAD;
                        count_d = '0;
                        len_d   = load_len;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (run_start) begin
                    state_d = PRIME;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = PRIME;
                    end
                end
            end
            PRIME: begin
                state_d = RUN;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Output logic; the core's memory port is only connected in RUN
    always_comb begin
        core_reset     = 1'b1;
        busy           = 1'b0;
        in_ready       = 1'b0;
        done           = 1'b0;
        pm_addr        = '0;
        pm_write_value = '0;
        pm_we          = 1'b0;
        unique case (state_q)
            HALT: begin
            end
            LOAD: begin
                busy           = 1'b1;
                in_ready       = 1'b1;
                pm_addr        = count_q[AW-1:0];
                pm_write_value = in_data;
                pm_we          = in_valid;
            end
            PRIME: begin
                busy = 1'b1;
                done = 1'b1;
            end
            RUN: begin
                core_reset     = 1'b0;
                pm_addr        = core_pm_addr;
                pm_write_value = core_pm_write_value;
                pm_we          = core_pm_we;
            end
            default: begin
            end
        endcase
    end

    assign error = error_q;

endmodule
